// File: rtl/m2_filler_multi.sv
// m2_filler_multi
//   Test-word filler for the frame buffer reader. On every word request the
//   read pointer is compared against CH configured slot addresses. A hit on
//   an armed channel emits that channel's test word (constant, up-count,
//   down-count, or down-count gated by odd groups) and disarms the channel,
//   so a pointer dwelling on a slot produces one word per dwell. Any request
//   outside all slots emits the idle fill word and re-arms every channel.
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   synchronous active-high reset
//   bufGetWord   in   word request
//   bufRdPointer in   buffer read address (PTR_W bits)
//   grpOddity    in   group counter, bit 0 = odd group
//   cntClear     in   synchronous clear of all channel counters
//   dataWord     out  registered output word (CNT_W+2 bits)
//   dataStrobe   out  one-cycle pulse when a slot word is loaded
module m2_filler_multi #(
  parameter int                     CH        = 4,
  parameter int                     PTR_W     = 8,
  parameter int                     CNT_W     = 10,
  parameter logic [CH*PTR_W-1:0]    SLOT_ADDR = {8'd8, 8'd64, 8'd0, 8'd128},
  parameter logic [CH*2-1:0]        SLOT_MODE = {2'd3, 2'd1, 2'd0, 2'd0},
  parameter logic [CNT_W-1:0]       CONST_VAL = CNT_W'(110),
  parameter logic [CNT_W+1:0]       FILL_WORD = (CNT_W+2)'(12'h002)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               bufGetWord,
  input  logic [PTR_W-1:0]   bufRdPointer,
  input  logic [4:0]         grpOddity,
  input  logic               cntClear,
  output logic [CNT_W+1:0]   dataWord,
  output logic               dataStrobe
);

  localparam int WORD_W = CNT_W + 2;
  localparam int SEL_W  = (CH > 1) ? $clog2(CH) : 1;

  logic [CH-1:0]     match;
  logic [CNT_W-1:0]  cnt_q [CH];
  logic [CNT_W-1:0]  cnt_d [CH];
  logic [CH-1:0]     armed_q, armed_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              strobe_q, strobe_d;

  logic              hit;
  logic [SEL_W-1:0]  sel;
  logic [1:0]        mode;
  logic [CNT_W-1:0]  cur;

  // Only the odd/even bit of the group counter matters here.
  logic unused_grp;
  assign unused_grp = ^grpOddity[4:1];

  genvar gi;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_match
      assign match[gi] = (bufRdPointer == SLOT_ADDR[gi*PTR_W +: PTR_W]);
    end
  endgenerate

  always_comb begin
    cnt_d    = cnt_q;
    armed_d  = armed_q;
    word_d   = word_q;
    strobe_d = 1'b0;
    hit      = 1'b0;
    sel      = '0;

    // Scan from the top so the lowest matching channel ends up selected.
    for (int k = CH - 1; k >= 0; k--) begin
      if (match[k]) begin
        hit = 1'b1;
        sel = SEL_W'(k);
      end
    end

    mode = SLOT_MODE[sel*2 +: 2];
    cur  = cnt_q[sel];

    if (bufGetWord) begin
      if (!hit) begin
        word_d  = FILL_WORD;
        armed_d = '1;
      end else if (armed_q[sel]) begin
        armed_d[sel] = 1'b0;
        case (mode)
          2'd0: begin
            word_d   = {1'b0, CONST_VAL, 1'b0};
            strobe_d = 1'b1;
          end
          2'd1: begin
            word_d       = {1'b0, cur, 1'b0};
            cnt_d[sel]   = cur + CNT_W'(1);
            strobe_d     = 1'b1;
          end
          2'd2: begin
            word_d       = {1'b0, cur, 1'b0};
            cnt_d[sel]   = cur - CNT_W'(1);
            strobe_d     = 1'b1;
          end
          default: begin
            // Odd-group channel: counts down on odd groups only; even
            // groups consume the dwell with the fill word.
            if (grpOddity[0]) begin
              word_d     = {1'b0, cur, 1'b0};
              cnt_d[sel] = cur - CNT_W'(1);
              strobe_d   = 1'b1;
            end else begin
              word_d     = FILL_WORD;
            end
          end
        endcase
      end
    end

    // Clear wins over any step taken this cycle; the emitted word above
    // already carries the pre-clear value.
    if (cntClear) begin
      for (int k = 0; k < CH; k++) begin
        cnt_d[k] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      word_q   <= '0;
      strobe_q <= 1'b0;
      armed_q  <= '1;
      for (int k = 0; k < CH; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      word_q   <= word_d;
      strobe_q <= strobe_d;
      armed_q  <= armed_d;
      for (int k = 0; k < CH; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  assign dataWord   = word_q;
  assign dataStrobe = strobe_q;

endmodule

// File: tb/tb_m2_filler_multi.sv
// Bench for m2_filler_multi. Two instances share the stimulus: A uses the
// default slot map, B has ch0 (const) and ch1 (up) both on address 64 so the
// priority rule is visible. A behavioural model per instance pushes the
// expected {word, strobe} into a queue as each request is driven; the queue
// is popped and compared one cycle later.
module tb_m2_filler_multi;

  logic        clk = 1'b0;
  logic        reset;
  logic        bufGetWord;
  logic [7:0]  bufRdPointer;
  logic [4:0]  grpOddity;
  logic        cntClear;
  logic [11:0] word_a, word_b;
  logic        strobe_a, strobe_b;

  always #5 clk = ~clk;

  m2_filler_multi dut_a (
    .clk(clk), .reset(reset), .bufGetWord(bufGetWord),
    .bufRdPointer(bufRdPointer), .grpOddity(grpOddity), .cntClear(cntClear),
    .dataWord(word_a), .dataStrobe(strobe_a)
  );

  m2_filler_multi #(
    .SLOT_ADDR({8'd9, 8'd7, 8'd64, 8'd64}),
    .SLOT_MODE({2'd0, 2'd0, 2'd1, 2'd0})
  ) dut_b (
    .clk(clk), .reset(reset), .bufGetWord(bufGetWord),
    .bufRdPointer(bufRdPointer), .grpOddity(grpOddity), .cntClear(cntClear),
    .dataWord(word_b), .dataStrobe(strobe_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model state, index 0 = instance A, 1 = instance B.
  int          addr_m  [2][4];
  int          mode_m  [2][4];
  logic [9:0]  cnt_m   [2][4];
  bit          armed_m [2][4];
  logic [11:0] word_m  [2];
  bit          strobe_m[2];
  logic [12:0] exp_q_a[$];
  logic [12:0] exp_q_b[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] slot_word(input logic [9:0] v);
    return {1'b0, v, 1'b0};
  endfunction

  task automatic model_step(input int i, input bit rst, input bit get, input int ptr,
                            input bit odd, input bit clr);
    int k;
    if (rst) begin
      word_m[i] = 12'h000;
      strobe_m[i] = 1'b0;
      for (int c = 0; c < 4; c++) begin
        cnt_m[i][c] = 10'd0;
        armed_m[i][c] = 1'b1;
      end
      return;
    end
    strobe_m[i] = 1'b0;
    if (get) begin
      k = -1;
      for (int c = 3; c >= 0; c--) if (addr_m[i][c] == ptr) k = c;
      if (k < 0) begin
        word_m[i] = 12'h002;
        for (int c = 0; c < 4; c++) armed_m[i][c] = 1'b1;
      end else if (armed_m[i][k]) begin
        armed_m[i][k] = 1'b0;
        if (mode_m[i][k] == 0) begin
          word_m[i] = slot_word(10'd110);
          strobe_m[i] = 1'b1;
        end else if (mode_m[i][k] == 1) begin
          word_m[i] = slot_word(cnt_m[i][k]);
          cnt_m[i][k] = cnt_m[i][k] + 10'd1;
          strobe_m[i] = 1'b1;
        end else if (mode_m[i][k] == 2 || odd) begin
          word_m[i] = slot_word(cnt_m[i][k]);
          cnt_m[i][k] = cnt_m[i][k] - 10'd1;
          strobe_m[i] = 1'b1;
        end else begin
          word_m[i] = 12'h002;
        end
      end
    end
    if (clr) for (int c = 0; c < 4; c++) cnt_m[i][c] = 10'd0;
  endtask

  // Drive one request, update models, push expectations, then compare.
  task automatic drive(input bit rst, input bit get, input int ptr, input int odd, input bit clr);
    logic [12:0] e;
    reset        = rst;
    bufGetWord   = get;
    bufRdPointer = 8'(ptr);
    grpOddity    = 5'(odd);
    cntClear     = clr;
    for (int i = 0; i < 2; i++) model_step(i, rst, get, ptr, grpOddity[0], clr);
    exp_q_a.push_back({word_m[0], strobe_m[0]});
    exp_q_b.push_back({word_m[1], strobe_m[1]});
    @(posedge clk);
    #1;
    $display("txn rst=%0b get=%0b ptr=%0d odd=%0d clr=%0b | A word=%h stb=%b | B word=%h stb=%b",
             rst, get, ptr, odd, clr, word_a, strobe_a, word_b, strobe_b);
    if (exp_q_a.size() == 0 || exp_q_b.size() == 0) begin
      check_val("queue_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q_a.pop_front();
      check_val("a_word", 32'(word_a), 32'(e[12:1]));
      check_val("a_strobe", 32'(strobe_a), 32'(e[0]));
      e = exp_q_b.pop_front();
      check_val("b_word", 32'(word_b), 32'(e[12:1]));
      check_val("b_strobe", 32'(strobe_b), 32'(e[0]));
    end
  endtask

  // One dwell on a slot followed by one idle-pointer request.
  task automatic dwell(input int ptr, input int odd);
    drive(1'b0, 1'b1, ptr, odd, 1'b0);
    drive(1'b0, 1'b1, 5, odd, 1'b0);
  endtask

  initial begin
    // Instance A map: ch0=128 const, ch1=0 const, ch2=64 up, ch3=8 odd-down.
    addr_m[0] = '{128, 0, 64, 8};
    mode_m[0] = '{0, 0, 1, 3};
    // Instance B map: ch0=64 const, ch1=64 up, ch2=7 const, ch3=9 const.
    addr_m[1] = '{64, 64, 7, 9};
    mode_m[1] = '{0, 1, 0, 0};

    reset = 1'b1; bufGetWord = 1'b0; bufRdPointer = '0; grpOddity = '0; cntClear = 1'b0;
    @(posedge clk);
    #1;

    // Reset held for two clocks with an active request on a slot.
    drive(1'b1, 1'b1, 64, 1, 1'b0);
    drive(1'b1, 1'b1, 64, 1, 1'b0);
    check_val("reset_word", 32'(word_a), 32'h000);

    // Up-count once per dwell.
    drive(1'b0, 1'b1, 64, 1, 1'b0);
    check_val("first_up_strobe", 32'(strobe_a), 32'd1);
    drive(1'b0, 1'b1, 64, 1, 1'b0);
    drive(1'b0, 1'b1, 64, 1, 1'b0);
    drive(1'b0, 1'b1, 5, 1, 1'b0);
    drive(1'b0, 1'b1, 64, 1, 1'b0);
    check_val("second_up_word", 32'(word_a), 32'h002);
    drive(1'b0, 1'b1, 5, 1, 1'b0);

    // Odd-group gating on ch3 (address 8).
    dwell(8, 1);
    dwell(8, 1);
    dwell(8, 2);
    dwell(8, 1);

    // Constant slots.
    dwell(0, 0);
    dwell(128, 0);

    // Idle: no requests for 10 clocks.
    for (int n = 0; n < 10; n++) drive(1'b0, 1'b0, 64, 1, 1'b0);

    // Full wrap of the up counter.
    for (int n = 0; n < 1024; n++) dwell(64, 0);

    // Step to 5, then clear during a hit.
    while (cnt_m[0][2] != 10'd5) dwell(64, 0);
    drive(1'b0, 1'b1, 64, 0, 1'b1);
    check_val("clear_hit_word", 32'(word_a), 32'h00A);
    drive(1'b0, 1'b1, 5, 0, 1'b0);
    drive(1'b0, 1'b1, 64, 0, 1'b0);
    check_val("after_clear_word", 32'(word_a), 32'h000);
    drive(1'b0, 1'b1, 5, 0, 1'b0);

    // Reset in the middle of a dwell re-arms the channel.
    dwell(64, 0);
    drive(1'b0, 1'b1, 64, 0, 1'b0);
    drive(1'b1, 1'b1, 64, 0, 1'b0);
    drive(1'b0, 1'b1, 64, 0, 1'b0);
    check_val("post_reset_strobe", 32'(strobe_a), 32'd1);
    check_val("dup_priority_word", 32'(word_b), 32'h0DC);
    drive(1'b0, 1'b1, 5, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
